scp_fetch_unit: RTL and testbench



---
 rtl/scp_pkg.sv | 15 +
 rtl/scp_fetch_unit.sv | 95 +++++++++
 tb/tb_scp_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scp_pkg.sv
// Shared types and constants for the single-cycle processor fetch path.
package scp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        HOLD,
        ERR
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/scp_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and
// hands the fetched word to the core, steering the next PC from branch feedback.
module scp_fetch_unit
    import scp_pkg::*;
#(
    parameter int unsigned       X_LEN    = 32,
    parameter logic [X_LEN-1:0]  RESET_PC = X_LEN'(DEFAULT_RESET_PC)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [X_LEN-1:0] imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
    output logic [31:0]      instr_o,
    output logic [X_LEN-1:0] instr_pc_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    input  logic             pc_sel_i,
    input  logic [X_LEN-1:0] branch_target_i,
    output logic             fetch_err_o,
    output logic [31:0]      retired_cnt_o
);

    fetch_state_e     state_q, state_d;
    logic [X_LEN-1:0] pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [X_LEN-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]      cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                // Responses are only meaningful here; anywhere else they are dropped.
                if (imem_rsp_valid_i) begin
                    instr_d    = imem_rsp_data_i;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    cnt_d = cnt_q + 32'd1;
                    if (!pc_sel_i) begin
                        pc_d    = pc_q + X_LEN'(INSTR_BYTES);
                        state_d = REQ;
                    end else if (branch_target_i[1:0] == 2'b00) begin
                        pc_d    = branch_target_i;
                        state_d = REQ;
                    end else begin
                        // Misaligned target: freeze the PC and park until reset.
                        state_d = ERR;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_valid_o = (state_q == REQ);
    assign imem_req_addr_o  = pc_q;
    assign instr_valid_o    = (state_q == HOLD);
    assign instr_o          = instr_q;
    assign instr_pc_o       = instr_pc_q;
    assign fetch_err_o      = (state_q == ERR);
    assign retired_cnt_o    = cnt_q;

endmodule

// File: tb/tb_scp_fetch_unit.sv
// Self-checking bench for scp_fetch_unit: directed scenarios plus a randomized
// fetch stream compared against a transaction-level PC/count model.
module tb_scp_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_sel;
    logic [31:0] target;
    logic        fetch_err;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: architectural PC, retire count, error flag.
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_err;
    int          last_req_cyc;

    scp_fetch_unit #(.X_LEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .pc_sel_i         (pc_sel),
        .branch_target_i  (target),
        .fetch_err_o      (fetch_err),
        .retired_cnt_o    (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req_valid"},   32'(req_valid),   32'd0);
        check32({tag, "_req_addr"},    req_addr,         32'h0);
        check32({tag, "_instr"},       instr,            32'h0);
        check32({tag, "_instr_pc"},    instr_pc,         32'h0);
        check32({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check32({tag, "_fetch_err"},   32'(fetch_err),   32'd0);
        check32({tag, "_retired"},     retired,          32'd0);
    endtask

    // Leaves the bench at the first REQ cycle after reset release.
    task automatic release_and_start(input string tag);
        rst_n = 1'b1;
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        exp_err = 1'b0;
        check32({tag, "_idle_no_req"}, 32'(req_valid), 32'd0);
        tick();
        check32({tag, "_first_req"}, 32'(req_valid), 32'd1);
        check32({tag, "_first_addr"}, req_addr, 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n       = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        target      = '0;
        #1;
        check_reset_outputs(tag);
        tick();
        tick();
        release_and_start(tag);
    endtask

    // One complete instruction: request (with stalls), response (with delay),
    // hold (with back-pressure and spurious responses), then accept.
    task automatic fetch_one(input int req_dly, input int rsp_dly, input int hold_dly,
                             input logic sel, input logic [31:0] tgt);
        int          n;
        logic [31:0] data;
        n = 0;
        while (!req_valid && n < 8) begin
            tick();
            n++;
        end
        check32("req_seen", 32'(req_valid), 32'd1);
        check32("req_addr", req_addr, exp_pc);
        last_req_cyc = cyc;
        for (int i = 0; i < req_dly; i++) begin
            req_ready = 1'b0;
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_data  = $urandom();
            tick();
            check32("req_valid_stable", 32'(req_valid), 32'd1);
            check32("req_addr_stable", req_addr, exp_pc);
        end
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check32("wait_no_req", 32'(req_valid), 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            check32("wait_no_instr", 32'(instr_valid), 32'd0);
        end
        data      = $urandom();
        rsp_valid = 1'b1;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        check32("hold_valid", 32'(instr_valid), 32'd1);
        check32("instr_data", instr, data);
        check32("instr_pc", instr_pc, exp_pc);
        for (int i = 0; i < hold_dly; i++) begin
            instr_ready = 1'b0;
            pc_sel      = 1'($urandom_range(0, 1));
            target      = $urandom();
            rsp_valid   = 1'($urandom_range(0, 1));
            rsp_data    = $urandom();
            tick();
            check32("hold_instr_stable", instr, data);
            check32("hold_pc_stable", instr_pc, exp_pc);
            check32("hold_no_req", 32'(req_valid), 32'd0);
            check32("hold_cnt", retired, exp_cnt);
        end
        rsp_valid   = 1'b0;
        instr_ready = 1'b1;
        pc_sel      = sel;
        target      = tgt;
        tick();
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        target      = $urandom();
        exp_cnt = exp_cnt + 1;
        if (!sel)                exp_pc = exp_pc + 32'd4;
        else if (tgt % 4 == 0)   exp_pc = tgt;
        else                     exp_err = 1'b1;
        check32("retired_cnt", retired, exp_cnt);
        check32("fetch_err", 32'(fetch_err), 32'(exp_err));
        check32("next_req_valid", 32'(req_valid), 32'(!exp_err));
        if (!exp_err) check32("next_req_addr", req_addr, exp_pc);
    endtask

    initial begin
        int prev_req;
        apply_reset("rst0");

        // Best-case loop: one instruction every 3 cycles, sequential PCs.
        fetch_one(0, 0, 0, 1'b0, 32'h0);
        prev_req = last_req_cyc;
        for (int k = 1; k < 3; k++) begin
            fetch_one(0, 0, 0, 1'b0, 32'h0);
            check32("req_spacing", 32'(last_req_cyc - prev_req), 32'd3);
            prev_req = last_req_cyc;
        end
        check32("retired_after_3", retired, 32'd3);

        // Reach pc=0x10, then take a branch to 0x100.
        fetch_one(0, 0, 0, 1'b0, 32'h0);
        check32("pc_at_0x10", req_addr, 32'h10);
        fetch_one(0, 0, 0, 1'b1, 32'h100);
        fetch_one(0, 0, 0, 1'b0, 32'h0);

        // Request stall of 4 cycles, response 3 cycles late.
        fetch_one(4, 3, 0, 1'b0, 32'h0);

        // Spurious responses in REQ/HOLD and 5 cycles of back-pressure.
        fetch_one(2, 0, 5, 1'b0, 32'h0);

        // Wrap at the top of the address space.
        fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(0, 0, 0, 1'b0, 32'h0);
        check32("pc_wrapped", req_addr, 32'h0);

        // Randomized stream with aligned targets.
        for (int k = 0; k < 25; k++) begin
            logic [31:0] t;
            t = $urandom() & 32'hFFFF_FFFC;
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), t);
        end

        // Misaligned target: sticky error, no more requests.
        fetch_one(0, 0, 1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            rsp_valid   = 1'b1;
            instr_ready = 1'b1;
            tick();
            check32("err_sticky", 32'(fetch_err), 32'd1);
            check32("err_no_req", 32'(req_valid), 32'd0);
            check32("err_no_instr", 32'(instr_valid), 32'd0);
            check32("err_cnt_frozen", retired, exp_cnt);
        end
        apply_reset("rst_err");

        // Reset during WAIT_RSP with a response in the same cycle.
        fetch_one(0, 0, 0, 1'b0, 32'h0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        tick();
        rsp_valid = 1'b0;
        check_reset_outputs("rst_wait_hold");
        release_and_start("rst_wait");
        fetch_one(0, 1, 0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
